axi_rd_responder: RTL and testbench
===================================

Name: axi_rd_responder

Overview:
- AXI3/AXI4 read-only slave model that sits directly downstream of the random-read traffic generator. It consumes its AR channel and returns R bursts.
- Supplies a deterministic, latency-controlled memory stand-in, so generator throughput (iocount_period) can be measured in simulation and on FPGA without HBM.
- Bursts are served strictly in order from an outstanding-request FIFO.
- Read data is derived from the beat address, so a checker can verify it.

Parameters:
- ADDR_LEN, 32, address width (must be <= DATA_LEN)
- DATA_LEN, 64, data width in bits (power of two, 32..1024)
- ID_LEN, 6, AXI ID width
- LEN_SIZE, 4, burst-length field width (4 = AXI3, 8 = AXI4)
- OUTSTANDING, 8, AR FIFO depth (power of two, 2..64)
- LATENCY, 8, minimum cycles from AR handshake to first R beat (1..16383)
- MEM_SIZE, 32'h1000_0000, decoded address range; used only by the optional feature

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion must be synchronous to clock (externally synchronised)
- axi_arid  in  ID_LEN  request ID
- axi_araddr  in  ADDR_LEN  burst start address
- axi_arlen  in  LEN_SIZE  beats minus one
- axi_arsize  in  3  log2 bytes per beat (must be <= log2(DATA_LEN/8))
- axi_arburst  in  2  burst type; INCR is the only supported type, other values are treated as INCR
- axi_arvalid  in  1  AR valid
- axi_arready  out  1  AR ready
- axi_rid  out  ID_LEN  response ID
- axi_rdata  out  DATA_LEN  response data
- axi_rresp  out  2  response code
- axi_rlast  out  1  last beat of burst
- axi_rvalid  out  1  R valid
- axi_rready  in  1  R ready
- outstanding  out  $clog2(OUTSTANDING)+1  accepted bursts not yet fully returned
- beat_count  out  32  total R beats handshaken since reset; wraps modulo 2^32

Behaviour:
- Reset values: axi_arready=0, axi_rvalid=0, axi_rlast=0, axi_rid=0, axi_rdata=0, axi_rresp=0, outstanding=0, beat_count=0. FIFO is emptied and the timestamp counter is cleared.
- Reset mid-burst: all in-flight and queued bursts are discarded. No R beat is produced after reset_n deasserts until a new AR is accepted.
- Timestamp: free-running 15-bit counter.
- AR acceptance:
  - axi_arready = FIFO not full; the signal is registered and low during reset.
  - On arvalid && arready, push {arid, araddr, arlen, arsize, stamp=timestamp}.
  - Full FIFO: arready=0 until a burst's rlast handshake frees an entry. A pop and a push in the same cycle keep the count unchanged.
- Latency eligibility:
  - The head entry is eligible when (timestamp - stamp) mod 2^15 >= LATENCY.
  - Consequence: if AR is handshaken at edge T, rvalid for the first beat rises no earlier than the cycle following edge T+LATENCY-1, i.e. it is visible at edge T+LATENCY.
- R state machine:
  - IDLE:
    - Head entry eligible -> BURST.
    - Load beat counter = 0 and beat address = araddr.
    - Drive rvalid=1 in the next cycle.
  - BURST:
    - rvalid=1; rid = entry ID; rresp=OKAY (2'b00); rlast = (beat counter == arlen).
    - rdata is zero-extended beat address in [ADDR_LEN-1:0]. The bits above are beat counter + 1 zero-extended, placed starting at bit ADDR_LEN.
    - While rvalid && !rready, every R output is held stable.
    - On handshake without rlast: beat counter +1, beat address += (1<<arsize) mod 2^ADDR_LEN. Wrap-around past the top of the address space is silent.
    - On handshake with rlast: pop the entry. If the next head is already eligible, present its first beat in the immediately following cycle (no bubble); otherwise -> IDLE with rvalid=0.
- Throughput: one beat per cycle sustained when rready=1 and the FIFO is non-empty.
- outstanding: +1 on AR handshake, -1 on rlast handshake; both in the same cycle leaves it unchanged.
- beat_count: +1 on every rvalid && rready.

Optional Feature:
- Macro: AXI_RD_RESPONDER_DECERR_EN.
- Defined:
  - A burst whose start address >= MEM_SIZE returns rresp=DECERR (2'b11) on every beat.
  - rdata is all zeros on those beats.
  - Beat count and timing are unchanged.
  - The decode decision is made at AR acceptance and stored as one extra FIFO bit.
- Undefined: every burst returns OKAY and MEM_SIZE is ignored.

Test Plan:
- Single burst, LATENCY=8:
  - Stimulus: AR id=5, addr=0x100, arlen=3, arsize=3; rready=1.
  - Response: first rvalid 8 cycles after AR handshake; 4 back-to-back beats.
  - Low data words (rdata[31:0]): 0x100, 0x108, 0x110, 0x118.
  - rid=5 on all beats; rlast only on beat 4; beat_count=4; outstanding returns to 0.
- FIFO full:
  - Stimulus: rready=0, arvalid held high with 9 distinct requests.
  - Response: 8 accepted, arready=0, outstanding=8.
  - Then raise rready: arready rises only after the first rlast handshake; bursts return in acceptance order.
- Backpressure:
  - Stimulus: arlen=7, rready toggling every cycle.
  - Response: all R outputs stable while rvalid && !rready; exactly 8 beats; addresses contiguous.
- Address wrap:
  - Stimulus: addr=0xFFFF_FFF8, arlen=1, arsize=3.
  - Response: beats with address 0xFFFF_FFF8 then 0x0000_0000; rlast on beat 2.
- Reset mid-burst:
  - Stimulus: assert reset_n=0 asynchronously during beat 2 of an 8-beat burst.
  - Response: rvalid drops immediately; after release, outstanding=0, beat_count=0, and no stale beats appear.
- Decode error (macro defined, MEM_SIZE=0x1000):
  - Stimulus: addr=0x2000, arlen=1.
  - Response: 2 beats with rresp=2'b11 and rdata=0. A following burst at addr=0x10 returns OKAY.

Source files
------------

// File: rtl/axi_rd_responder_if.sv
// axi_rd_responder_if: AXI read-only bus (AR + R channels).
// master drives AR and rready; slave drives arready and R.
interface axi_rd_responder_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 64,
    parameter int ID_LEN   = 6,
    parameter int LEN_SIZE = 4
);
    logic [ID_LEN-1:0]   axi_arid;
    logic [ADDR_LEN-1:0] axi_araddr;
    logic [LEN_SIZE-1:0] axi_arlen;
    logic [2:0]          axi_arsize;
    logic [1:0]          axi_arburst;
    logic                axi_arvalid;
    logic                axi_arready;
    logic [ID_LEN-1:0]   axi_rid;
    logic [DATA_LEN-1:0] axi_rdata;
    logic [1:0]          axi_rresp;
    logic                axi_rlast;
    logic                axi_rvalid;
    logic                axi_rready;

    modport master (
        output axi_arid, axi_araddr, axi_arlen, axi_arsize,
        output axi_arburst, axi_arvalid, axi_rready,
        input  axi_arready, axi_rid, axi_rdata, axi_rresp,
        input  axi_rlast, axi_rvalid
    );

    modport slave (
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize,
        input  axi_arburst, axi_arvalid, axi_rready,
        output axi_arready, axi_rid, axi_rdata, axi_rresp,
        output axi_rlast, axi_rvalid
    );
endinterface

// File: rtl/axi_rd_responder.sv
// axi_rd_responder: in-order AXI read slave with fixed minimum latency.
// Ports: clock, reset_n (async low), bus (slave modport: AR in, R out),
//   outstanding (bursts accepted, not yet returned), beat_count (R beats).
// Optional: define AXI_RD_RESPONDER_DECERR_EN for DECERR at addr >= MEM_SIZE.
// rdata = {beat index + 1, beat address}; zero on DECERR bursts.
module axi_rd_responder #(
    parameter int          ADDR_LEN    = 32,
    parameter int          DATA_LEN    = 64,
    parameter int          ID_LEN      = 6,
    parameter int          LEN_SIZE    = 4,
    parameter int          OUTSTANDING = 8,
    parameter int          LATENCY     = 8,
    parameter logic [31:0] MEM_SIZE    = 32'h1000_0000
) (
    input  logic                         clock,
    input  logic                         reset_n,
    axi_rd_responder_if.slave            bus,
    output logic [$clog2(OUTSTANDING):0] outstanding,
    output logic [31:0]                  beat_count
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int TW = 15;
    localparam int LW = LEN_SIZE + 1;
    localparam int CW = (ADDR_LEN > 32) ? ADDR_LEN : 32;

    typedef struct packed {
        logic                err;
        logic [TW-1:0]       stamp;
        logic [2:0]          size;
        logic [LEN_SIZE-1:0] len;
        logic [ADDR_LEN-1:0] addr;
        logic [ID_LEN-1:0]   id;
    } ent_t;

    typedef enum logic {IDLE, BURST} state_t;

    ent_t                fifo [OUTSTANDING];
    logic [PW-1:0]       wr_ptr, rd_ptr, nx_ptr;
    logic [PW:0]         cnt, cnt_nxt;
    logic [TW-1:0]       ts;
    state_t              state;
    logic [LEN_SIZE-1:0] beat, cur_len, adv_beat;
    logic [ADDR_LEN-1:0] addr, adv_addr;
    logic [2:0]          cur_size;
    logic                cur_err;
    logic                push, pop, hs, head_ok, next_ok;
    logic                load, adv, fin, dec_err;
    ent_t                head, nxt, ld;
    logic                unused_ok;

    // Age is taken modulo 2^15 so the free-running stamp may wrap.
    function automatic logic ripe(input logic [TW-1:0] now,
                                  input logic [TW-1:0] stamp);
        logic [TW-1:0] age;
        age = now - stamp;
        return age >= TW'(LATENCY);
    endfunction

    function automatic logic [DATA_LEN-1:0] beat_data(
        input logic [ADDR_LEN-1:0] a,
        input logic [LEN_SIZE-1:0] n,
        input logic                err
    );
        logic [DATA_LEN-1:0] d;
        d = DATA_LEN'(a) | (DATA_LEN'(LW'(n) + LW'(1)) << ADDR_LEN);
        return err ? '0 : d;
    endfunction

`ifdef AXI_RD_RESPONDER_DECERR_EN
    assign dec_err   = CW'(bus.axi_araddr) >= CW'(MEM_SIZE);
    assign unused_ok = ^bus.axi_arburst;
`else
    assign dec_err   = 1'b0;
    assign unused_ok = ^{bus.axi_arburst, MEM_SIZE};
`endif

    assign hs       = bus.axi_rvalid && bus.axi_rready;
    assign pop      = hs && bus.axi_rlast;
    assign push     = bus.axi_arvalid && bus.axi_arready;
    assign cnt_nxt  = cnt + (PW+1)'(push) - (PW+1)'(pop);
    assign nx_ptr   = rd_ptr + PW'(1);
    assign head     = fifo[rd_ptr];
    assign nxt      = fifo[nx_ptr];
    assign head_ok  = (cnt != '0) && ripe(ts, head.stamp);
    // An entry pushed this cycle is never ripe, so cnt > 1 suffices.
    assign next_ok  = (cnt > (PW+1)'(1)) && ripe(ts, nxt.stamp);
    assign ld       = (state == BURST) ? nxt : head;
    assign load     = ((state == IDLE) && head_ok) || (pop && next_ok);
    assign adv      = hs && !bus.axi_rlast;
    assign fin      = pop && !next_ok;
    assign adv_beat = beat + LEN_SIZE'(1);
    assign adv_addr = addr + (ADDR_LEN'(1) << cur_size);

    assign outstanding = cnt;

    always_ff @(posedge clock) begin
        if (push)
            fifo[wr_ptr] <= '{dec_err, ts, bus.axi_arsize, bus.axi_arlen,
                              bus.axi_araddr, bus.axi_arid};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts              <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cnt             <= '0;
            beat_count      <= '0;
            bus.axi_arready <= 1'b0;
        end else begin
            ts              <= ts + TW'(1);
            cnt             <= cnt_nxt;
            bus.axi_arready <= cnt_nxt != (PW+1)'(OUTSTANDING);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= nx_ptr;
            if (hs)   beat_count <= beat_count + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            beat           <= '0;
            cur_len        <= '0;
            cur_size       <= '0;
            cur_err        <= 1'b0;
            addr           <= '0;
            bus.axi_rvalid <= 1'b0;
            bus.axi_rlast  <= 1'b0;
            bus.axi_rid    <= '0;
            bus.axi_rdata  <= '0;
            bus.axi_rresp  <= '0;
        end else begin
            unique case (1'b1)
                load: begin
                    state          <= BURST;
                    beat           <= '0;
                    addr           <= ld.addr;
                    cur_len        <= ld.len;
                    cur_size       <= ld.size;
                    cur_err        <= ld.err;
                    bus.axi_rvalid <= 1'b1;
                    bus.axi_rid    <= ld.id;
                    bus.axi_rdata  <= beat_data(ld.addr, '0, ld.err);
                    bus.axi_rresp  <= {2{ld.err}};
                    bus.axi_rlast  <= ld.len == '0;
                end
                adv: begin
                    beat          <= adv_beat;
                    addr          <= adv_addr;
                    bus.axi_rdata <= beat_data(adv_addr, adv_beat, cur_err);
                    bus.axi_rlast <= adv_beat == cur_len;
                end
                fin: begin
                    state          <= IDLE;
                    bus.axi_rvalid <= 1'b0;
                    bus.axi_rlast  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_responder.sv
// tb_axi_rd_responder: directed + random bursts vs a burst-queue model.
// Checks beats, ordering, latency, backpressure hold, counters, reset.
module tb_axi_rd_responder;
    localparam int          LAT  = 8;
    localparam int          OUTS = 8;
    localparam logic [31:0] MEM  = 32'h1000;

    typedef struct {
        logic [5:0]  id;
        logic [31:0] addr;
        int          len;
        int          size;
        int          acc;
        int          beat;
        bit          shown;
        bit          err;
    } bst_t;

    logic        clock;
    logic        reset_n;
    logic [3:0]  outstanding;
    logic [31:0] beat_count;

    axi_rd_responder_if #(
        .ADDR_LEN(32), .DATA_LEN(64), .ID_LEN(6), .LEN_SIZE(4)
    ) bus ();

    axi_rd_responder #(
        .ADDR_LEN(32), .DATA_LEN(64), .ID_LEN(6), .LEN_SIZE(4),
        .OUTSTANDING(OUTS), .LATENCY(LAT), .MEM_SIZE(MEM)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .outstanding (outstanding),
        .beat_count  (beat_count)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          rmode = 0;
    bit          armed = 0;
    bit          stall = 0;
    int          rv_cnt = 0;
    int          first_vis = 0;
    logic [31:0] mdl_beats = 0;
    bst_t        q [$];
    bst_t        cur;
    int          acc_q [$];
    int          start_cyc [$];
    int          done_cyc [$];
    logic [31:0] lo_q [$];
    logic [63:0] dd_q [$];
    logic [1:0]  rr_q [$];
    bit          last_q [$];
    logic [5:0]  p_rid;
    logic [63:0] p_rdata;
    logic [1:0]  p_rresp;
    logic        p_rlast;
    logic [31:0] ea;
    logic [63:0] ed;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        #1;
        case (rmode)
            0:       bus.axi_rready = 1'b1;
            1:       bus.axi_rready = ~bus.axi_rready;
            2:       bus.axi_rready = 1'($urandom);
            default: bus.axi_rready = 1'b0;
        endcase
    end

    // Reference model: queue of accepted bursts, one expected beat at a time.
    always @(negedge clock) begin
        if (reset_n) begin
            if (q.size() == 0) chk("stale_rv", bus.axi_rvalid, 0);
            chk("outst", outstanding, q.size());
            chk("beat_cnt", beat_count, mdl_beats);
            if (armed) chk("arready", bus.axi_arready, q.size() != OUTS);
            if (stall) begin
                chk("hold_rv", bus.axi_rvalid, 1);
                chk("hold_rid", bus.axi_rid, p_rid);
                chk("hold_rdata", bus.axi_rdata, p_rdata);
                chk("hold_rresp", bus.axi_rresp, p_rresp);
                chk("hold_rlast", bus.axi_rlast, p_rlast);
            end
            stall   = bus.axi_rvalid && !bus.axi_rready;
            p_rid   = bus.axi_rid;
            p_rdata = bus.axi_rdata;
            p_rresp = bus.axi_rresp;
            p_rlast = bus.axi_rlast;
            if (bus.axi_rvalid) rv_cnt++;
            if (bus.axi_rvalid && q.size() > 0 && !q[0].shown) begin
                q[0].shown = 1;
                first_vis  = cyc;
                chk("lat_min", (cyc - q[0].acc) >= LAT, 1);
            end
            if (bus.axi_rvalid && bus.axi_rready && q.size() > 0) begin
                cur = q[0];
                ea  = cur.addr + 32'(cur.beat << cur.size);
                ed  = cur.err ? 64'd0 : {32'(cur.beat + 1), ea};
                chk("rid", bus.axi_rid, cur.id);
                chk("rdata", bus.axi_rdata, ed);
                chk("rresp", bus.axi_rresp, cur.err ? 2'b11 : 2'b00);
                chk("rlast", bus.axi_rlast, cur.beat == cur.len);
                lo_q.push_back(bus.axi_rdata[31:0]);
                dd_q.push_back(bus.axi_rdata);
                rr_q.push_back(bus.axi_rresp);
                last_q.push_back(bus.axi_rlast);
                if (cur.beat == 0) start_cyc.push_back(cyc + 1);
                mdl_beats = mdl_beats + 1;
                if (cur.beat == cur.len) begin
                    void'(q.pop_front());
                    done_cyc.push_back(cyc + 1);
                end else begin
                    cur.beat = cur.beat + 1;
                    q[0] = cur;
                end
            end
            if (bus.axi_arvalid && bus.axi_arready) begin
                cur.id    = bus.axi_arid;
                cur.addr  = bus.axi_araddr;
                cur.len   = int'(bus.axi_arlen);
                cur.size  = int'(bus.axi_arsize);
                cur.acc   = cyc + 1;
                cur.beat  = 0;
                cur.shown = 0;
`ifdef AXI_RD_RESPONDER_DECERR_EN
                cur.err   = bus.axi_araddr >= MEM;
`else
                cur.err   = 0;
`endif
                q.push_back(cur);
                acc_q.push_back(cyc + 1);
            end
        end
    end

    task automatic model_reset();
        q.delete();
        mdl_beats = 0;
        stall     = 0;
        armed     = 0;
        rv_cnt    = 0;
    endtask

    task automatic wait_ar(input int budget);
        int n = 0;
        bit ok = 0;
        while (!ok && n < budget) begin
            @(negedge clock);
            if (bus.axi_arready) ok = 1;
            @(posedge clock);
            #1;
            n++;
        end
        bus.axi_arvalid = 1'b0;
        if (!ok) chk("ar_timeout", 0, 1);
    endtask

    task automatic drive_ar(input logic [5:0] id, input logic [31:0] a,
                            input int len, input int sz, input int bu);
        bus.axi_arid    = id;
        bus.axi_araddr  = a;
        bus.axi_arlen   = 4'(len);
        bus.axi_arsize  = 3'(sz);
        bus.axi_arburst = 2'(bu);
        bus.axi_arvalid = 1'b1;
    endtask

    task automatic send_ar(input logic [5:0] id, input logic [31:0] a,
                           input int len, input int sz);
        drive_ar(id, a, len, sz, 1);
        wait_ar(2000);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk(tag, q.size(), 0);
    endtask

    task automatic clear_logs();
        lo_q.delete();
        dd_q.delete();
        rr_q.delete();
        last_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] exp1 [4];
        int          ba, bs, bd, n;
        logic [31:0] a;

        exp1 = '{32'h100, 32'h108, 32'h110, 32'h118};
        reset_n = 0;
        bus.axi_arvalid = 0;
        bus.axi_arid    = 0;
        bus.axi_araddr  = 0;
        bus.axi_arlen   = 0;
        bus.axi_arsize  = 0;
        bus.axi_arburst = 0;
        bus.axi_rready  = 1;
        #2;
        chk("rst_arready", bus.axi_arready, 0);
        chk("rst_rvalid", bus.axi_rvalid, 0);
        chk("rst_rlast", bus.axi_rlast, 0);
        chk("rst_rid", bus.axi_rid, 0);
        chk("rst_rdata", bus.axi_rdata, 0);
        chk("rst_rresp", bus.axi_rresp, 0);
        chk("rst_outst", outstanding, 0);
        chk("rst_beats", beat_count, 0);
        repeat (4) @(posedge clock);
        #1 reset_n = 1;
        repeat (2) @(posedge clock);
        #1 armed = 1;

        // single burst
        rmode = 0;
        clear_logs();
        send_ar(6'd5, 32'h100, 3, 3);
        wait_drain("t1_drain", 200);
        chk("t1_lat", first_vis - acc_q[acc_q.size()-1], LAT);
        chk("t1_nbeats", lo_q.size(), 4);
        for (int i = 0; i < 4 && i < lo_q.size(); i++) begin
            chk("t1_lo", lo_q[i], exp1[i]);
            chk("t1_last", last_q[i], i == 3);
        end
        chk("t1_b2b", done_cyc[done_cyc.size()-1]
                      - start_cyc[start_cyc.size()-1], 3);
        chk("t1_beat_count", beat_count, 4);
        chk("t1_outst", outstanding, 0);

        // FIFO full, then drain in order without bubbles
        rmode = 3;
        repeat (2) @(posedge clock);
        #1;
        ba = acc_q.size();
        bs = start_cyc.size();
        bd = done_cyc.size();
        for (int i = 0; i < 8; i++) send_ar(6'(10 + i), 32'(i * 64), 1, 3);
        drive_ar(6'd18, 32'h1000, 1, 3, 0);
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("t2_outst_full", outstanding, 8);
        chk("t2_arready_full", bus.axi_arready, 0);
        @(posedge clock);
        #1 rmode = 0;
        wait_ar(200);
        wait_drain("t2_drain", 400);
        chk("t2_nacc", acc_q.size() - ba, 9);
        chk("t2_ndone", done_cyc.size() - bd, 9);
        if (acc_q.size() - ba == 9 && done_cyc.size() - bd == 9) begin
            chk("t2_ar9_edge", acc_q[ba+8], done_cyc[bd] + 1);
            chk("t2_streak", done_cyc[bd+7] - start_cyc[bs] + 1, 16);
        end

        // backpressure
        rmode = 1;
        clear_logs();
        send_ar(6'd33, 32'h2000, 7, 3);
        wait_drain("t3_drain", 400);
        chk("t3_nbeats", lo_q.size(), 8);
        for (int i = 0; i < lo_q.size(); i++)
            chk("t3_contig", lo_q[i], 32'h2000 + 32'(i * 8));

        // address wrap
        rmode = 0;
        clear_logs();
        send_ar(6'd7, 32'hFFFF_FFF8, 1, 3);
        wait_drain("t4_drain", 200);
        chk("t4_nbeats", lo_q.size(), 2);
        if (lo_q.size() == 2) begin
            chk("t4_a0", lo_q[0], 32'hFFFF_FFF8);
            chk("t4_a1", lo_q[1], 32'h0);
            chk("t4_l0", last_q[0], 0);
            chk("t4_l1", last_q[1], 1);
        end

`ifdef AXI_RD_RESPONDER_DECERR_EN
        clear_logs();
        send_ar(6'd9, 32'h2000, 1, 3);
        send_ar(6'd10, 32'h10, 0, 3);
        wait_drain("t5_drain", 200);
        chk("t5_nbeats", dd_q.size(), 3);
        if (dd_q.size() == 3) begin
            chk("t5_r0", rr_q[0], 2'b11);
            chk("t5_d0", dd_q[0], 0);
            chk("t5_r1", rr_q[1], 2'b11);
            chk("t5_d1", dd_q[1], 0);
            chk("t5_r2", rr_q[2], 2'b00);
            chk("t5_d2", dd_q[2], {32'd1, 32'h10});
        end
`endif

        // random traffic
        for (int i = 0; i < 40; i++) begin
            rmode = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFF;
            drive_ar(6'($urandom), a, $urandom_range(0, 15),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            wait_ar(2000);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end
        rmode = 0;
        wait_drain("t6_drain", 5000);

        // reset during beat 2 of an 8-beat burst
        send_ar(6'd21, 32'h400, 7, 3);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(bus.axi_rvalid && bus.axi_rdata[63:32] == 32'd2)
                   && n < 200);
        chk("t7_reach_b2", n < 200, 1);
        #1 reset_n = 0;
        model_reset();
        #1;
        chk("t7_rv_drop", bus.axi_rvalid, 0);
        chk("t7_outst_async", outstanding, 0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1;
        repeat (2) @(posedge clock);
        #1 armed = 1;
        repeat (20) @(posedge clock);
        #1;
        chk("t7_outst", outstanding, 0);
        chk("t7_beats", beat_count, 0);
        chk("t7_no_stale", rv_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
